vector_scan_out: RTL

//  Downstream stage of memory_manage: scans the vector frame RAM point by point and drives the X/Y DACs plus beam enable.
//  One frame is scanned per frame_ready/frame_ack handshake; memory_manage must not write the RAM while busy=1.

---
 rtl/vector_scan_out_if.sv | 32 +++
 rtl/vector_scan_out.sv | 116 +++++++++++
 2 files changed

// File: rtl/vector_scan_out_if.sv
`default_nettype none
//==============================================================================
// Interface : vector_scan_out_if
// Frame handshake, frame RAM read port and DAC/beam outputs of the vector scanner.
// Revision  : 1.0
//==============================================================================
interface vector_scan_out_if #(
    parameter int ADR_WIDTH = 7,
    parameter int DAC_WIDTH = 8,
    parameter int DATAWIDTH = 18
);
    logic                 frame_ready;
    logic                 frame_ack;
    logic                 busy;
    logic [ADR_WIDTH-1:0] adr_rd;
    logic [DATAWIDTH-1:0] data_rd;
    logic [DAC_WIDTH-1:0] x_dac;
    logic [DAC_WIDTH-1:0] y_dac;
    logic                 z_beam;
    logic                 point_strobe;

    modport master (
        input  frame_ready, data_rd,
        output frame_ack, busy, adr_rd, x_dac, y_dac, z_beam, point_strobe
    );

    modport slave (
        output frame_ready, data_rd,
        input  frame_ack, busy, adr_rd, x_dac, y_dac, z_beam, point_strobe
    );
endinterface
`default_nettype wire

// File: rtl/vector_scan_out.sv
`default_nettype none
//==============================================================================
// Module   : vector_scan_out
// Scans the vector frame RAM point by point, driving X/Y DACs and beam enable.
// Optional : VSCAN_STATE_DEBUG_EN adds the state_debug[2:0] output.
// Revision : 1.0
//==============================================================================
module vector_scan_out #(
    parameter int ADR_WIDTH = 7,
    parameter int DAC_WIDTH = 8,
    parameter int DATAWIDTH = 18,
    parameter int DEPTH     = 100,
    parameter int DWELL     = 4
) (
    input  logic              clk,
    input  logic              rst,
    vector_scan_out_if.master bus
`ifdef VSCAN_STATE_DEBUG_EN
    ,
    output logic [2:0]        state_debug
`endif
);

    localparam int                   END_BIT  = DATAWIDTH - 1;
    localparam int                   BEAM_BIT = DATAWIDTH - 2;
    localparam int                   CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(DEPTH - 1);
    localparam logic [DAC_WIDTH-1:0] PARK     = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]     DWELL_LD = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_DWELL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;
    logic             go_done;

    // Both routes into DONE (END word, or last address dwelled) share the same output update.
    always_comb begin
        go_done = 1'b0;
        if (state == S_LATCH && bus.data_rd[END_BIT])
            go_done = 1'b1;
        if (state == S_DWELL && dwell_cnt == '0 && bus.adr_rd == LAST_ADR)
            go_done = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            dwell_cnt        <= '0;
            bus.adr_rd       <= '0;
            bus.x_dac        <= PARK;
            bus.y_dac        <= PARK;
            bus.z_beam       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.frame_ack    <= 1'b0;
            bus.point_strobe <= 1'b0;
        end else begin
            bus.frame_ack    <= 1'b0;
            bus.point_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.frame_ready) begin
                        bus.adr_rd <= '0;
                        bus.busy   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_LATCH;
                S_LATCH: begin
                    if (!bus.data_rd[END_BIT]) begin
                        bus.x_dac        <= bus.data_rd[DAC_WIDTH-1:0];
                        bus.y_dac        <= bus.data_rd[2*DAC_WIDTH-1:DAC_WIDTH];
                        bus.z_beam       <= bus.data_rd[BEAM_BIT];
                        bus.point_strobe <= 1'b1;
                        dwell_cnt        <= DWELL_LD;
                        state            <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (bus.adr_rd != LAST_ADR) begin
                        bus.adr_rd <= bus.adr_rd + 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (go_done) begin
                bus.frame_ack <= 1'b1;
                bus.busy      <= 1'b0;
                bus.z_beam    <= 1'b0;
                bus.x_dac     <= PARK;
                bus.y_dac     <= PARK;
                bus.adr_rd    <= '0;
                state         <= S_DONE;
            end
        end
    end

`ifdef VSCAN_STATE_DEBUG_EN
    assign state_debug = state;
`endif

endmodule
`default_nettype wire
